// File: rtl/sram1rw_param_pkg.sv
// Shared definitions for the parametrised single-port SRAM model and its clear sequencer.
// Contents: FSM state encoding and default geometry parameters.
package sram1rw_param_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int unsigned DEF_ADDR_W  = 6;
  localparam int unsigned DEF_DEPTH   = 64;
  localparam int unsigned DEF_DATA_W  = 128;
  localparam int unsigned DEF_SEG_W   = 8;
  localparam int unsigned DEF_OUT_REG = 0;
  localparam int unsigned DEF_CLR_EN  = 1;

endpackage

// File: rtl/sram1rw_param_clr_seq.sv
// Post-reset memory-clear sequencer: walks every word once, zeroing it, then holds READY.
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   clr_we_c    combinational write strobe for the zeroing write this cycle
//   clr_addr    word address being cleared (registered counter)
//   busy        registered; 1 while the sequence runs, drops on entry to READY
module sram1rw_param_clr_seq
  import sram1rw_param_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned CLR_EN = DEF_CLR_EN
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_we_c,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State, counter and busy registers; reset restarts the walk from word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLR_EN != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
      busy    <= (CLR_EN != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d == ST_CLEAR);
    end
  end

  // Next-state: the last word is written on the same edge that enters READY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_c = 1'b0;
    if (state_q == ST_CLEAR) begin
      clr_we_c = 1'b1;
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = ST_READY;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/sram1rw_param.sv
// Parametrised single-port synchronous SRAM with segment write mask, optional output
// pipeline register, read-valid strobe and post-reset clear.
// Ports:
//   CE_i     clock, rising edge          RSTB_i  asynchronous active-low reset
//   CSB_i    chip select, active low     WEB_i   0 = write, 1 = read
//   OEB_i    output enable, active low   A_i     word address
//   I_i      write data                  BWEB_i  per-segment write enable, active low
//   O_i      read data, high-Z when OEB_i=1
//   VALID_o  pulse when the O_i source register was loaded by a read
//   BUSY_o   1 while the clear sequence runs
module sram1rw_param
  import sram1rw_param_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned SEG_W   = DEF_SEG_W,
  parameter int unsigned OUT_REG = DEF_OUT_REG,
  parameter int unsigned CLR_EN  = DEF_CLR_EN
) (
  input  logic                     CE_i,
  input  logic                     RSTB_i,
  input  logic                     CSB_i,
  input  logic                     WEB_i,
  input  logic                     OEB_i,
  input  logic [ADDR_W-1:0]        A_i,
  input  logic [DATA_W-1:0]        I_i,
  input  logic [DATA_W/SEG_W-1:0]  BWEB_i,
  output logic [DATA_W-1:0]        O_i,
  output logic                     VALID_o,
  output logic                     BUSY_o
);

  localparam int unsigned NSEG  = DATA_W / SEG_W;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we_c;
  logic [ADDR_W-1:0] clr_addr;
  logic              busy;

  logic              in_range_c;
  logic [IDX_W-1:0]  idx_c;
  logic              rd_c;
  logic              wr_c;
  logic [DATA_W-1:0] rd_word_c;
  logic [DATA_W-1:0] wr_word_c;

  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] pipe_q;
  logic              rd_q;
  logic              rd_q2;

  sram1rw_param_clr_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .CLR_EN (CLR_EN)
  ) u_clr_seq (
    .clk      (CE_i),
    .rst_n    (RSTB_i),
    .clr_we_c (clr_we_c),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  // Access decode: only when ready; X/Z on CSB_i/WEB_i fails both identity tests, i.e. no access.
  assign in_range_c = (32'(A_i) < DEPTH);
  assign idx_c      = IDX_W'(A_i);
  assign rd_c       = !busy && (CSB_i === 1'b0) && (WEB_i === 1'b1);
  assign wr_c       = !busy && (CSB_i === 1'b0) && (WEB_i === 1'b0);
  assign rd_word_c  = in_range_c ? mem[idx_c] : '0;

  // Segment merge: unmasked segments take write data, the rest keep the stored word.
  always_comb begin
    wr_word_c = rd_word_c;
    for (int s = 0; s < int'(NSEG); s++) begin
      if (!BWEB_i[s]) begin
        wr_word_c[s*SEG_W +: SEG_W] = I_i[s*SEG_W +: SEG_W];
      end
    end
  end

  // Array: clear writes take priority; out-of-range writes are dropped. Not reset.
  always_ff @(posedge CE_i) begin
    if (clr_we_c) begin
      mem[IDX_W'(clr_addr)] <= '0;
    end else if (wr_c && in_range_c) begin
      mem[idx_c] <= wr_word_c;
    end
  end

  // Read data and optional pipeline stage; writes never touch dout (no write-through).
  always_ff @(posedge CE_i or negedge RSTB_i) begin
    if (!RSTB_i) begin
      dout_q <= '0;
      pipe_q <= '0;
      rd_q   <= 1'b0;
      rd_q2  <= 1'b0;
    end else begin
      if (rd_c) begin
        dout_q <= rd_word_c;
      end
      if (rd_q) begin
        pipe_q <= dout_q;
      end
      rd_q  <= rd_c;
      rd_q2 <= rd_q;
    end
  end

  assign VALID_o = (OUT_REG != 0) ? rd_q2 : rd_q;
  assign BUSY_o  = busy;
  assign O_i     = OEB_i ? 'z : ((OUT_REG != 0) ? pipe_q : dout_q);

endmodule

// File: tb/tb_sram1rw_param.sv
// Bench for sram1rw_param: two instances (OUT_REG=0 and OUT_REG=1) share stimulus and are
// compared against a word-array model of the memory and its read latency.
module tb_sram1rw_param;

  localparam int unsigned AW    = 7;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned DW    = 128;
  localparam int unsigned SW    = 8;
  localparam int unsigned NS    = DW / SW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          csb, web, oeb;
  logic [AW-1:0] a;
  logic [DW-1:0] din;
  logic [NS-1:0] bweb;
  wire  [DW-1:0] o0, o1;
  logic          v0, v1, b0, b1;

  always #5 clk = ~clk;

  sram1rw_param #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW), .SEG_W(SW), .OUT_REG(0), .CLR_EN(1)) dut0 (
    .CE_i(clk), .RSTB_i(rst_n), .CSB_i(csb), .WEB_i(web), .OEB_i(oeb), .A_i(a), .I_i(din),
    .BWEB_i(bweb), .O_i(o0), .VALID_o(v0), .BUSY_o(b0));

  sram1rw_param #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW), .SEG_W(SW), .OUT_REG(1), .CLR_EN(1)) dut1 (
    .CE_i(clk), .RSTB_i(rst_n), .CSB_i(csb), .WEB_i(web), .OEB_i(oeb), .A_i(a), .I_i(din),
    .BWEB_i(bweb), .O_i(o1), .VALID_o(v1), .BUSY_o(b1));

  // Reference model state
  logic [DW-1:0] mem_m [DEPTH];
  int            busy_left;
  logic [DW-1:0] dout_m, pipe_m;
  logic          v0_m, v1_m, prev_rd;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_hiz(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] data);
    n_chk++;
    assert (obs !== data) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h required=high-Z (not %h)", tag, obs, data);
    end
  endtask

  // One clock edge of the model: clear period ignores accesses, then read/write semantics.
  task automatic model_edge();
    if (busy_left > 0) begin
      busy_left--;
      v0_m    = 1'b0;
      v1_m    = 1'b0;
      prev_rd = 1'b0;
    end else begin
      v1_m = prev_rd;
      if (prev_rd) pipe_m = dout_m;
      if (csb == 1'b0 && web == 1'b1) begin
        if (32'(a) < DEPTH) dout_m = mem_m[a];
        else                dout_m = '0;
        v0_m    = 1'b1;
        prev_rd = 1'b1;
      end else begin
        v0_m    = 1'b0;
        prev_rd = 1'b0;
        if (csb == 1'b0 && web == 1'b0 && 32'(a) < DEPTH) begin
          for (int s = 0; s < int'(NS); s++)
            if (!bweb[s]) mem_m[a][s*SW +: SW] = din[s*SW +: SW];
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("busy0", DW'(b0), DW'(busy_left != 0));
    chk("busy1", DW'(b1), DW'(busy_left != 0));
    chk("valid0", DW'(v0), DW'(v0_m));
    chk("valid1", DW'(v1), DW'(v1_m));
    if (!oeb) begin
      chk("dout0", o0, dout_m);
      chk("dout1", o1, pipe_m);
    end
  endtask

  task automatic cycle(input logic c, input logic w, input logic [AW-1:0] addr,
                       input logic [DW-1:0] d, input logic [NS-1:0] be);
    csb = c; web = w; a = addr; din = d; bweb = be;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Asynchronous reset: check immediately, hold over one edge, release after it.
  task automatic do_reset();
    csb = 1'b1; web = 1'b1;
    rst_n = 1'b0;
    dout_m = '0; pipe_m = '0; v0_m = 1'b0; v1_m = 1'b0; prev_rd = 1'b0;
    busy_left = DEPTH;
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [DW-1:0] pat_a5;
  logic [DW-1:0] pat_mask;

  initial begin
    rst_n = 1'b1; csb = 1'b1; web = 1'b1; oeb = 1'b0;
    a = '0; din = '0; bweb = '1;
    pat_a5   = {16{8'hA5}};
    pat_mask = {{15{8'hA5}}, 8'hFF};
    #2;

    // 1: reset, clear runs DEPTH edges, all words read back 0
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) cycle(1'b1, 1'b1, '0, '0, '1);
    for (int i = 0; i < int'(DEPTH); i++) cycle(1'b0, 1'b1, AW'(i), '0, '1);
    cycle(1'b1, 1'b1, '0, '0, '1);

    // 2: full write then read, both latencies
    cycle(1'b0, 1'b0, AW'(5), pat_a5, '0);
    cycle(1'b0, 1'b1, AW'(5), '0, '1);
    chk("t2_o0", o0, pat_a5);
    cycle(1'b1, 1'b1, '0, '0, '1);
    chk("t2_o1", o1, pat_a5);

    // 3: masked write touches segment 0 only; read immediately follows write
    cycle(1'b0, 1'b0, AW'(5), '1, 16'hFFFE);
    cycle(1'b0, 1'b1, AW'(5), '0, '1);
    chk("t3_o0", o0, pat_mask);
    cycle(1'b1, 1'b1, '0, '0, '1);
    chk("t3_o1", o1, pat_mask);

    // 4: output disabled during read, then enabled without a clock edge
    oeb = 1'b1;
    cycle(1'b0, 1'b1, AW'(5), '0, '1);
    chk_hiz("t4_hiz0", o0, pat_mask);
    cycle(1'b1, 1'b1, '0, '0, '1);
    chk_hiz("t4_hiz1", o1, pat_mask);
    oeb = 1'b0;
    #1;
    chk("t4_oe0", o0, pat_mask);
    chk("t4_oe1", o1, pat_mask);

    // 5/6: reset mid-clear restarts; writes during clear ignored
    do_reset();
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, AW'(i), '1, '0);
    do_reset();
    cycle(1'b0, 1'b0, AW'(3), '1, '0);
    for (int i = 1; i < int'(DEPTH); i++) cycle(1'b0, i[0], AW'(i), rnd_word(), '0);
    cycle(1'b0, 1'b1, AW'(3), '0, '1);
    chk("t6_busy_wr", o0, '0);

    // 6: out-of-range address: read returns 0 with valid, write dropped (no alias to word 6)
    cycle(1'b0, 1'b0, AW'(6), pat_a5, '0);
    cycle(1'b0, 1'b0, AW'(70), '1, '0);
    cycle(1'b0, 1'b1, AW'(70), '0, '1);
    chk("t6_oor_rd", o0, '0);
    chk("t6_oor_v", DW'(v0), DW'(1'b1));
    cycle(1'b0, 1'b1, AW'(6), '0, '1);
    chk("t6_alias", o0, pat_a5);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic          c, w;
      logic [AW-1:0] ad;
      logic [NS-1:0] be;
      c  = ($urandom_range(0, 3) == 0);
      w  = $urandom_range(0, 1) == 1;
      ad = AW'($urandom_range(0, int'(DEPTH) + 7));
      be = ($urandom_range(0, 5) == 0) ? '1 : NS'($urandom());
      cycle(c, w, ad, rnd_word(), be);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
